// File: rtl/l2_pkg.sv
// Shared types and default sizes for the L2 request arbiter slice.
package l2_pkg;
   localparam int L2_NCORES = 4;
   localparam int L2_ADDR_W = 13;
   localparam int L2_DATA_W = 64;

   typedef struct packed {
      logic                 write;
      logic [L2_ADDR_W-1:0] addr;
      logic [L2_DATA_W-1:0] wdata;
   } l2_req_t;

   typedef logic [$clog2(L2_NCORES)-1:0] core_id_t;
endpackage

// File: rtl/l2_rr_picker.sv
// Rotating-priority picker: first full buffer at or after rr_ptr, wrapping modulo NCORES.
module l2_rr_picker import l2_pkg::*; #(
   parameter int NCORES = L2_NCORES,
   parameter int ID_W   = $clog2(L2_NCORES)
) (
   input  logic [NCORES-1:0] full_i,
   input  logic [ID_W-1:0]   rr_ptr_i,
   output logic              grant_valid_o,
   output logic [ID_W-1:0]   grant_id_o
);

   // Walk from the farthest offset down so the nearest full slot to rr_ptr is the last write.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_id_o    = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         if (full_i[(int'(rr_ptr_i) + k) % NCORES]) begin
            grant_valid_o = 1'b1;
            grant_id_o    = ID_W'((int'(rr_ptr_i) + k) % NCORES);
         end
      end
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// Per-core request buffers, round-robin grant onto the single L2 port, read-data return routing.
module l2_request_arbiter import l2_pkg::*; #(
   parameter int NCORES = L2_NCORES,
   parameter int ADDR_W = L2_ADDR_W,
   parameter int DATA_W = L2_DATA_W,
   parameter int L2_LAT = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NCORES-1:0]        core_req_valid,
   output logic [NCORES-1:0]        core_req_ready,
   input  logic [NCORES-1:0]        core_req_write,
   input  logic [NCORES*ADDR_W-1:0] core_req_addr,
   input  logic [NCORES*DATA_W-1:0] core_req_wdata,
   output logic [NCORES-1:0]        core_rsp_valid,
   output logic [DATA_W-1:0]        core_rsp_rdata,
   output logic                     l2_read,
   output logic                     l2_write,
   output logic [ADDR_W-1:0]        l2_address,
   output logic [DATA_W-1:0]        l2_datain,
   input  logic [DATA_W-1:0]        l2_dataout
);

   l2_req_t             req_q [NCORES];
   logic [NCORES-1:0]   full_q, full_d, ready_q, rsp_valid_q;
   core_id_t            rr_ptr_q, grant_id;
   logic                grant_valid, issue_rd;
   logic                l2_read_q, l2_write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   datain_q, rdata_q;
   logic [L2_LAT-1:0]   vld_pipe_q;
   core_id_t            id_pipe_q [L2_LAT];

   l2_rr_picker #(.NCORES(NCORES), .ID_W($bits(core_id_t))) u_picker (
      .full_i        (full_q),
      .rr_ptr_i      (rr_ptr_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   assign issue_rd = grant_valid & ~req_q[grant_id].write;

   // A granted buffer is never refilled in the same cycle: its ready was already low.
   always_comb begin
      full_d = full_q;
      for (int i = 0; i < NCORES; i++) begin
         if (grant_valid && grant_id == core_id_t'(i))
            full_d[i] = 1'b0;
         else if (core_req_valid[i] && ready_q[i])
            full_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q      <= '0;
         ready_q     <= '1;
         rr_ptr_q    <= '0;
         l2_read_q   <= 1'b0;
         l2_write_q  <= 1'b0;
         addr_q      <= '0;
         datain_q    <= '0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         vld_pipe_q  <= '0;
         for (int s = 0; s < L2_LAT; s++) id_pipe_q[s] <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ~full_d;
         for (int i = 0; i < NCORES; i++) begin
            if (core_req_valid[i] && ready_q[i])
               req_q[i] <= '{write: core_req_write[i],
                             addr:  core_req_addr[i*ADDR_W +: ADDR_W],
                             wdata: core_req_wdata[i*DATA_W +: DATA_W]};
         end

         l2_read_q  <= issue_rd;
         l2_write_q <= grant_valid & req_q[grant_id].write;
         if (grant_valid) begin
            addr_q   <= req_q[grant_id].addr;
            datain_q <= req_q[grant_id].wdata;
            rr_ptr_q <= core_id_t'((int'(grant_id) + 1) % NCORES);
         end

         // Read tags ride alongside the L2 latency so data lands on the right core.
         vld_pipe_q[0] <= issue_rd;
         id_pipe_q[0]  <= grant_id;
         for (int s = 1; s < L2_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            id_pipe_q[s]  <= id_pipe_q[s-1];
         end

         rsp_valid_q <= '0;
         if (vld_pipe_q[L2_LAT-1]) begin
            rsp_valid_q[id_pipe_q[L2_LAT-1]] <= 1'b1;
            rdata_q                          <= l2_dataout;
         end
      end
   end

   assign core_req_ready = ready_q;
   assign core_rsp_valid = rsp_valid_q;
   assign core_rsp_rdata = rdata_q;
   assign l2_read        = l2_read_q;
   assign l2_write       = l2_write_q;
   assign l2_address     = addr_q;
   assign l2_datain      = datain_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter with an 8K x 64 L2 model (read data follows l2_address).
module tb_l2_request_arbiter;
   localparam int N = 4, AW = 13, DW = 64;

   logic            clock = 1'b0, reset = 1'b1;
   logic [N-1:0]    core_req_valid, core_req_ready, core_req_write, core_rsp_valid;
   logic [N*AW-1:0] core_req_addr;
   logic [N*DW-1:0] core_req_wdata;
   logic [DW-1:0]   core_rsp_rdata, l2_datain, l2_dataout;
   logic            l2_read, l2_write;
   logic [AW-1:0]   l2_address;

   logic [N-1:0]    vld = '1, wr = '0;
   logic [AW-1:0]   addr [N];
   logic [DW-1:0]   wd   [N];

   logic [DW-1:0]   mem [8192];
   logic [8191:0]   written = '0;
   int              n_chk = 0, n_pass = 0;

   always #5 clock = ~clock;

   l2_request_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .L2_LAT(1)) dut (
      .clock(clock), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
      .core_req_write(core_req_write), .core_req_addr(core_req_addr),
      .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
      .core_rsp_rdata(core_rsp_rdata), .l2_read(l2_read), .l2_write(l2_write),
      .l2_address(l2_address), .l2_datain(l2_datain), .l2_dataout(l2_dataout)
   );

   always_comb begin
      core_req_valid = vld;
      core_req_write = wr;
      core_req_addr  = '0;
      core_req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         core_req_addr[i*AW +: AW]  = addr[i];
         core_req_wdata[i*DW +: DW] = wd[i];
      end
   end

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 13'h0A5) return 64'h1234;
      return {32'hC0DE0000, 19'b0, a};
   endfunction

   always @(posedge clock) begin
      if (l2_write) begin
         mem[l2_address]     <= l2_datain;
         written[l2_address] <= 1'b1;
      end
   end
   assign l2_dataout = written[l2_address] ? mem[l2_address] : init_val(l2_address);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vld   = '1;
      tick();
      tick();
      reset = 1'b0;
      vld   = '0;
   endtask

   int a_edge, g_edge, c3_cnt, b2b;
   logic prev_c0;

   initial begin
      for (int i = 0; i < N; i++) begin
         addr[i] = AW'(13'h40 + i);
         wd[i]   = '0;
      end

      // Reset with all valids high
      do_reset();
      chk("rst_ready", core_req_ready, 4'b1111);
      chk("rst_rd", l2_read, 0);
      chk("rst_wr", l2_write, 0);
      chk("rst_rsp", core_rsp_valid, 0);
      chk("rst_rdata", core_rsp_rdata, 0);
      tick();
      chk("rst_nocap_ready", core_req_ready, 4'b1111);
      chk("rst_nocap_rd", l2_read, 0);

      // Core 2 single read
      vld[2] = 1'b1; addr[2] = 13'h0A5;
      tick();
      vld = '0;
      chk("c2_ready_low", core_req_ready, 4'b1011);
      tick();
      chk("c2_l2_read", l2_read, 1);
      chk("c2_l2_addr", l2_address, 13'h0A5);
      chk("c2_l2_write", l2_write, 0);
      tick();
      chk("c2_rsp_valid", core_rsp_valid, 4'b0100);
      chk("c2_rdata", core_rsp_rdata, 64'h1234);
      tick();
      chk("c2_rsp_drop", core_rsp_valid, 0);

      // Four simultaneous reads from rr_ptr=0
      do_reset();
      for (int i = 0; i < N; i++) addr[i] = AW'(13'h10 + i);
      vld = '1;
      tick();
      vld = '0;
      chk("all_ready_low", core_req_ready, 4'b0000);
      tick();
      chk("all_e1_addr", l2_address, 13'h10);
      chk("all_e1_rd", l2_read, 1);
      chk("all_e1_ready", core_req_ready, 4'b0001);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("all_issue_addr", l2_address, 64'(13'h10 + k));
         chk("all_rsp_vld", core_rsp_valid, 4'b0001 << (k - 1));
         chk("all_rsp_data", core_rsp_rdata, init_val(AW'(13'h10 + k - 1)));
      end
      tick();
      chk("all_last_rsp", core_rsp_valid, 4'b1000);
      chk("all_last_data", core_rsp_rdata, init_val(13'h13));
      chk("all_rd_idle", l2_read, 0);
      chk("all_rr_ptr", dut.rr_ptr_q, 0);

      // Core 1 write then read to 0x1FFF
      vld[1] = 1'b1; wr[1] = 1'b1; addr[1] = 13'h1FFF; wd[1] = 64'hDEADBEEF00000001;
      tick();
      vld = '0;
      tick();
      chk("wr_l2_write", l2_write, 1);
      chk("wr_l2_read", l2_read, 0);
      chk("wr_addr", l2_address, 13'h1FFF);
      chk("wr_data", l2_datain, 64'hDEADBEEF00000001);
      vld[1] = 1'b1; wr[1] = 1'b0;
      tick();
      vld = '0;
      chk("wr_no_rsp", core_rsp_valid, 0);
      tick();
      chk("wrrd_l2_read", l2_read, 1);
      chk("wrrd_no_rsp", core_rsp_valid, 0);
      tick();
      chk("wrrd_rsp", core_rsp_valid, 4'b0010);
      chk("wrrd_data", core_rsp_rdata, 64'hDEADBEEF00000001);

      // Fairness: core 0 streaming, core 3 once
      addr[0] = 13'h100; addr[3] = 13'h333; wr = '0;
      a_edge = -1; g_edge = -1; c3_cnt = 0; b2b = 0; prev_c0 = 1'b0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         vld[0] = 1'b1;
         vld[3] = (cyc == 4);
         if (cyc == 4 && core_req_ready[3]) a_edge = cyc;
         tick();
         if (l2_read && l2_address == 13'h333) begin
            c3_cnt++;
            g_edge = cyc;
         end
         if (l2_read && l2_address == 13'h100) begin
            if (prev_c0) b2b++;
            prev_c0 = 1'b1;
         end else prev_c0 = 1'b0;
      end
      vld = '0;
      chk("fair_c3_once", c3_cnt, 1);
      chk("fair_c3_bound", (a_edge >= 0 && g_edge > a_edge && g_edge - a_edge <= 4), 1);
      chk("fair_c0_b2b", b2b, 0);
      repeat (4) tick();

      // Reset while reads in flight
      addr[0] = 13'h20; addr[1] = 13'h21;
      vld = 4'b0011;
      tick();
      vld = '1;
      tick();
      chk("mid_issue", l2_read, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_rsp", core_rsp_valid, 0);
      chk("mid_rst_ready", core_req_ready, 4'b1111);
      tick();
      reset = 1'b0;
      vld = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_no_rsp", core_rsp_valid, 0);
         chk("mid_no_rd", l2_read, 0);
      end
      chk("mid_ready", core_req_ready, 4'b1111);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
